// File: rtl/stall_ctrl_pkg.sv
// stall_ctrl_pkg: shared definitions for the pipeline stall/flush controller.
//   state_t  - controller state encodings
//   ctrl_t   - bundle of the combinational hold/bubble/flush strobes
//   DEF_*    - default parameter values
package stall_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_DRAIN    = 2'd2,
      ST_HALTED   = 2'd3
   } state_t;

   typedef struct packed {
      logic hold_pc;
      logic hold_ifid;
      logic hold_idex;
      logic bubble_idex;
      logic flush_ifid;
   } ctrl_t;

   localparam int unsigned DEF_CNT_W        = 4;
   localparam int unsigned DEF_MEM_WAIT_MAX = 15;
   localparam int unsigned DEF_DRAIN_CYCLES = 3;

endpackage

// File: rtl/stall_ctrl_wait_counter.sv
// stall_ctrl_wait_counter: CNT_W-bit saturating up-counter shared by the
// memory-wait timeout and the drain sequence.
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset (count <= 0)
//   clr   - synchronous clear (highest priority after rst)
//   load1 - synchronous load of 1
//   inc   - increment enable; holds at all-ones instead of wrapping
//   cnt   - current count
module stall_ctrl_wait_counter #(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load1,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             cnt_en;

   // Enable-flop style: the register only loads when one of the controls is
   // active, so an idle counter simply holds its value.
   always_comb begin
      cnt_en = clr | load1 | (inc & (cnt_q != CNT_MAX));
      if (clr) begin
         cnt_d = '0;
      end else if (load1) begin
         cnt_d = CNT_ONE;
      end else begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (cnt_en) begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/stall_ctrl.sv
// stall_ctrl: pipeline stall/flush controller for the RISCII core.
// Drives the S (hold) pins of the PC, IF/ID and ID/EX enable-flop registers,
// plus bubble/flush strobes, and sequences memory waits (with timeout) and
// a drain-then-halt sequence.
//   clk, rst              - clock and synchronous active-high reset
//   mem_req, mem_ack      - memory access in flight / completing this cycle
//   hzd_load_use          - load-use hazard in ID
//   branch_taken          - taken branch/jump resolved in EX
//   halt_req, resume      - enter / leave the halted state
//   hold_pc/ifid/idex     - combinational S inputs (1 keeps current value)
//   bubble_idex           - load NOP into ID/EX
//   flush_ifid            - load NOP into IF/ID
//   halted, mem_timeout   - registered status; mem_timeout is sticky until rst
module stall_ctrl
   import stall_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W        = DEF_CNT_W,
   parameter int unsigned MEM_WAIT_MAX = DEF_MEM_WAIT_MAX,
   parameter int unsigned DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic mem_req,
   input  logic mem_ack,
   input  logic hzd_load_use,
   input  logic branch_taken,
   input  logic halt_req,
   input  logic resume,
   output logic hold_pc,
   output logic hold_ifid,
   output logic hold_idex,
   output logic bubble_idex,
   output logic flush_ifid,
   output logic halted,
   output logic mem_timeout
);

   localparam logic [CNT_W-1:0] WAIT_LIMIT  = CNT_W'(MEM_WAIT_MAX);
   localparam logic [CNT_W-1:0] DRAIN_LIMIT = CNT_W'(DRAIN_CYCLES);

   state_t           state_q, state_d;
   logic             halted_q, halted_d;
   logic             timeout_q, timeout_d;
   logic             cnt_clr, cnt_load1, cnt_inc;
   logic [CNT_W-1:0] cnt;
   logic             stall;
   ctrl_t            ctrl;

   assign stall = mem_req & ~mem_ack;

   stall_ctrl_wait_counter #(
      .CNT_W (CNT_W)
   ) u_wait_counter (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .load1 (cnt_load1),
      .inc   (cnt_inc),
      .cnt   (cnt)
   );

   // State and status registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_RUN;
         halted_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         halted_q  <= halted_d;
         timeout_q <= timeout_d;
      end
   end

   // Next-state, counter control and status updates.
   always_comb begin
      state_d   = state_q;
      halted_d  = halted_q;
      timeout_d = timeout_q;
      cnt_clr   = 1'b0;
      cnt_load1 = 1'b0;
      cnt_inc   = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (stall) begin
               cnt_load1 = 1'b1;
               state_d   = ST_MEM_WAIT;
            end else if (!branch_taken && !hzd_load_use && halt_req) begin
               cnt_load1 = 1'b1;
               state_d   = ST_DRAIN;
            end else begin
               cnt_clr = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            // Branch/halt presented during the ack cycle are dropped; their
            // sources hold or re-present them.
            if (mem_ack) begin
               cnt_clr = 1'b1;
               state_d = ST_RUN;
            end else if (cnt < WAIT_LIMIT) begin
               cnt_inc = 1'b1;
            end else begin
               timeout_d = 1'b1;
               halted_d  = 1'b1;
               state_d   = ST_HALTED;
            end
         end
         ST_DRAIN: begin
            // A stall freezes the drain count until memory catches up.
            if (!stall) begin
               cnt_inc = 1'b1;
               if (cnt >= DRAIN_LIMIT) begin
                  halted_d = 1'b1;
                  state_d  = ST_HALTED;
               end
            end
         end
         ST_HALTED: begin
            if (resume && !timeout_q) begin
               cnt_clr  = 1'b1;
               halted_d = 1'b0;
               state_d  = ST_RUN;
            end
         end
         default: begin
            cnt_clr = 1'b1;
            state_d = ST_RUN;
         end
      endcase
   end

   // Combinational strobes; they act at the same edge as the causing event.
   always_comb begin
      ctrl = '0;
      if (!rst) begin
         case (state_q)
            ST_RUN: begin
               if (stall) begin
                  ctrl.hold_pc   = 1'b1;
                  ctrl.hold_ifid = 1'b1;
                  ctrl.hold_idex = 1'b1;
               end else if (branch_taken) begin
                  // ID holds a wrong-path instruction, so flush beats load-use.
                  ctrl.flush_ifid  = 1'b1;
                  ctrl.bubble_idex = 1'b1;
               end else if (hzd_load_use) begin
                  ctrl.hold_pc     = 1'b1;
                  ctrl.hold_ifid   = 1'b1;
                  ctrl.bubble_idex = 1'b1;
               end else if (halt_req) begin
                  ctrl.hold_pc    = 1'b1;
                  ctrl.flush_ifid = 1'b1;
               end
            end
            ST_MEM_WAIT: begin
               if (!mem_ack) begin
                  ctrl.hold_pc   = 1'b1;
                  ctrl.hold_ifid = 1'b1;
                  ctrl.hold_idex = 1'b1;
               end
            end
            ST_DRAIN: begin
               ctrl.hold_pc    = 1'b1;
               ctrl.flush_ifid = 1'b1;
               if (stall) begin
                  ctrl.hold_ifid = 1'b1;
                  ctrl.hold_idex = 1'b1;
               end
            end
            ST_HALTED: begin
               ctrl.hold_pc   = 1'b1;
               ctrl.hold_ifid = 1'b1;
               ctrl.hold_idex = 1'b1;
            end
            default: ctrl = '0;
         endcase
      end
   end

   assign hold_pc     = ctrl.hold_pc;
   assign hold_ifid   = ctrl.hold_ifid;
   assign hold_idex   = ctrl.hold_idex;
   assign bubble_idex = ctrl.bubble_idex;
   assign flush_ifid  = ctrl.flush_ifid;
   assign halted      = halted_q;
   assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl: table-driven and randomized self-checking bench for stall_ctrl.
// Output vectors are packed as
//   {hold_pc, hold_ifid, hold_idex, bubble_idex, flush_ifid, halted, mem_timeout}
// Input vectors are packed as
//   {rst, mem_req, mem_ack, hzd_load_use, branch_taken, halt_req, resume}
module tb_stall_ctrl;

   localparam int MEM_WAIT_MAX = 15;
   localparam int DRAIN_CYCLES = 3;

   typedef struct packed {
      logic       rst;
      logic       req;
      logic       ack;
      logic       hzd;
      logic       br;
      logic       halt;
      logic       res;
      logic [6:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst, mem_req, mem_ack, hzd_load_use, branch_taken, halt_req, resume;
   logic hold_pc, hold_ifid, hold_idex, bubble_idex, flush_ifid, halted, mem_timeout;

   int n_tests = 0;
   int n_fail  = 0;
   int step_no = 0;

   // Reference model: flags for "waiting on memory", "draining", "stopped";
   // held counts cycles the pipe has been held for the current access,
   // prog counts completed (non-stalled) drain cycles.
   bit m_wait, m_drain, m_stop, m_halted, m_tmo;
   int m_held, m_prog;

   always #5 clk = ~clk;

   stall_ctrl #(
      .CNT_W        (4),
      .MEM_WAIT_MAX (MEM_WAIT_MAX),
      .DRAIN_CYCLES (DRAIN_CYCLES)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_req      (mem_req),
      .mem_ack      (mem_ack),
      .hzd_load_use (hzd_load_use),
      .branch_taken (branch_taken),
      .halt_req     (halt_req),
      .resume       (resume),
      .hold_pc      (hold_pc),
      .hold_ifid    (hold_ifid),
      .hold_idex    (hold_idex),
      .bubble_idex  (bubble_idex),
      .flush_ifid   (flush_ifid),
      .halted       (halted),
      .mem_timeout  (mem_timeout)
   );

   function automatic vec_t mk(input logic [6:0] i, input logic [6:0] e);
      return vec_t'({i, e});
   endfunction

   function automatic logic [6:0] model_out(input vec_t v);
      logic       s;
      logic [4:0] c;
      s = v.req & ~v.ack;
      c = '0;
      if (!v.rst) begin
         if (m_wait) begin
            if (!v.ack) c = 5'b11100;
         end else if (m_drain) begin
            c = s ? 5'b11101 : 5'b10001;
         end else if (m_stop) begin
            c = 5'b11100;
         end else if (s) begin
            c = 5'b11100;
         end else if (v.br) begin
            c = 5'b00011;
         end else if (v.hzd) begin
            c = 5'b11010;
         end else if (v.halt) begin
            c = 5'b10001;
         end
      end
      return {c, m_halted, m_tmo};
   endfunction

   task automatic model_step(input vec_t v);
      logic s;
      s = v.req & ~v.ack;
      if (v.rst) begin
         m_wait = 0; m_drain = 0; m_stop = 0; m_halted = 0; m_tmo = 0;
         m_held = 0; m_prog = 0;
      end else if (m_wait) begin
         if (v.ack) begin
            m_wait = 0;
         end else begin
            m_held++;
            if (m_held > MEM_WAIT_MAX) begin
               m_wait = 0; m_stop = 1; m_halted = 1; m_tmo = 1;
            end
         end
      end else if (m_drain) begin
         if (!s) begin
            m_prog++;
            if (m_prog == DRAIN_CYCLES) begin
               m_drain = 0; m_stop = 1; m_halted = 1;
            end
         end
      end else if (m_stop) begin
         if (v.res && !m_tmo) begin
            m_stop = 0; m_halted = 0;
         end
      end else if (s) begin
         m_wait = 1; m_held = 1;
      end else if (!v.br && !v.hzd && v.halt) begin
         m_drain = 1; m_prog = 0;
      end
   endtask

   // Drive one cycle, compare (against v.exp or the model), then clock it.
   task automatic apply(input string name, input vec_t v, input bit use_tbl);
      logic [6:0] act, exp;
      rst = v.rst; mem_req = v.req; mem_ack = v.ack; hzd_load_use = v.hzd;
      branch_taken = v.br; halt_req = v.halt; resume = v.res;
      #1;
      exp = use_tbl ? v.exp : model_out(v);
      act = {hold_pc, hold_ifid, hold_idex, bubble_idex, flush_ifid, halted, mem_timeout};
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %b, want %b", name, step_no, act, exp);
      end
      step_no++;
      @(posedge clk);
      model_step(v);
      @(negedge clk);
   endtask

   vec_t tbl[23];

   initial begin
      // {rst,req,ack,hzd,br,halt,res} -> {hpc,hifid,hidex,bub,flush,halted,tmo}
      tbl[0]  = mk(7'b1101010, 7'b0000000);  // reset with noisy inputs
      tbl[1]  = mk(7'b1010101, 7'b0000000);
      tbl[2]  = mk(7'b0000000, 7'b0000000);  // idle
      tbl[3]  = mk(7'b0100000, 7'b1110000);  // stall in RUN
      tbl[4]  = mk(7'b0100000, 7'b1110000);
      tbl[5]  = mk(7'b0100000, 7'b1110000);
      tbl[6]  = mk(7'b0100000, 7'b1110000);
      tbl[7]  = mk(7'b0110110, 7'b0000000);  // ack: advance, br/halt dropped
      tbl[8]  = mk(7'b0000000, 7'b0000000);
      tbl[9]  = mk(7'b0001100, 7'b0001100);  // branch beats load-use
      tbl[10] = mk(7'b0001000, 7'b1101000);  // load-use alone
      tbl[11] = mk(7'b0001000, 7'b1101000);
      tbl[12] = mk(7'b0000110, 7'b0001100);  // branch beats halt
      tbl[13] = mk(7'b0000000, 7'b0000000);
      tbl[14] = mk(7'b0000010, 7'b1000100);  // halt request
      tbl[15] = mk(7'b0000000, 7'b1000100);  // drain 1
      tbl[16] = mk(7'b0100000, 7'b1110100);  // stall freezes drain
      tbl[17] = mk(7'b0001100, 7'b1000100);  // drain 2, br/hzd ignored
      tbl[18] = mk(7'b0000000, 7'b1000100);  // drain 3
      tbl[19] = mk(7'b0000000, 7'b1110010);  // halted
      tbl[20] = mk(7'b0000010, 7'b1110010);  // halt_req ignored
      tbl[21] = mk(7'b0000001, 7'b1110010);  // resume
      tbl[22] = mk(7'b0000000, 7'b0000000);  // back in RUN

      rst = 1'b1; mem_req = 0; mem_ack = 0; hzd_load_use = 0;
      branch_taken = 0; halt_req = 0; resume = 0;
      @(posedge clk);
      model_step(mk(7'b1000000, 7'b0));
      @(negedge clk);

      for (int i = 0; i < 23; i++) apply("table", tbl[i], 1'b1);

      // Timeout: 16 held cycles, then sticky halt that resume cannot clear.
      for (int i = 0; i < MEM_WAIT_MAX + 1; i++) apply("timeout_hold", mk(7'b0100000, 7'b1110000), 1'b1);
      for (int i = 0; i < 3; i++) apply("timeout_resume", mk(7'b0000001, 7'b1110011), 1'b1);
      apply("timeout_rst", mk(7'b1000000, 7'b0000011), 1'b1);
      apply("timeout_clear", mk(7'b0000000, 7'b0000000), 1'b1);

      // Reset mid-wait at cnt=7, then a fresh stall must take the full 16.
      for (int i = 0; i < 7; i++) apply("midrst_wait", mk(7'b0100000, 7'b1110000), 1'b1);
      apply("midrst_rst", mk(7'b1100000, 7'b0000000), 1'b1);
      apply("midrst_idle", mk(7'b0000000, 7'b0000000), 1'b1);
      for (int i = 0; i < MEM_WAIT_MAX + 1; i++) apply("midrst_restart", mk(7'b0100000, 7'b1110000), 1'b1);
      apply("midrst_timeout", mk(7'b0100000, 7'b1110011), 1'b1);
      apply("midrst_rst2", mk(7'b1000000, 7'b0000011), 1'b1);
      apply("midrst_idle2", mk(7'b0000000, 7'b0000000), 1'b1);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         vec_t v;
         v      = '0;
         v.rst  = ($urandom_range(0, 99) < 2);
         v.req  = ($urandom_range(0, 99) < 35);
         v.ack  = ($urandom_range(0, 99) < 45);
         v.hzd  = ($urandom_range(0, 99) < 20);
         v.br   = ($urandom_range(0, 99) < 20);
         v.halt = ($urandom_range(0, 99) < 10);
         v.res  = ($urandom_range(0, 99) < 30);
         apply("random", v, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/stall_ctrl.md
Name: stall_ctrl

Overview:
- Pipeline stall/flush controller for the RISCII core.
- Generates the per-stage hold (S) inputs that drive the enable-flop pipeline registers (PC, IF/ID, ID/EX), plus bubble/flush strobes.
- Sequences multi-cycle memory waits with a timeout and a drain-then-halt sequence.
- Sits directly upstream of the enable-flop register banks; its hold outputs connect to their S pins (S=1 keeps the current value).

Parameters:
- CNT_W, 4, width of the shared wait/drain counter.
- MEM_WAIT_MAX, 15, maximum MEM_WAIT cycles before timeout; must be ≤ 2^CNT_W-1.
- DRAIN_CYCLES, 3, cycles spent draining in-flight instructions before HALTED; must be ≥1 and ≤ 2^CNT_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_req  in  1  memory stage has an access in flight this cycle.
- mem_ack  in  1  memory access completes this cycle.
- hzd_load_use  in  1  load-use hazard detected in ID.
- branch_taken  in  1  taken branch/jump resolved in EX.
- halt_req  in  1  halt request; single-cycle pulse or level.
- resume  in  1  leave HALTED.
- hold_pc  out  1  S for PC register.
- hold_ifid  out  1  S for IF/ID register.
- hold_idex  out  1  S for ID/EX register.
- bubble_idex  out  1  load NOP into ID/EX.
- flush_ifid  out  1  load NOP into IF/ID.
- halted  out  1  registered; core is halted.
- mem_timeout  out  1  registered, sticky; memory wait exceeded MEM_WAIT_MAX.

Behaviour:
- One clock (clk). Reset rst is synchronous and active-high.
- rst=1 at an edge sets: state=RUN, cnt=0, halted=0, mem_timeout=0.
- While rst=1, all combinational outputs (hold_*, bubble_idex, flush_ifid) are forced to 0.
- hold_*, bubble_idex and flush_ifid are combinational from state and current inputs, so they take effect at the same edge as the event.
- halted and mem_timeout come from flops.
- Define stall = mem_req & ~mem_ack.

States:
- RUN, priority order (highest first):
  1. stall: all holds=1; cnt<=1; go to MEM_WAIT.
  2. branch_taken: flush_ifid=1, bubble_idex=1; holds=0. Branch beats load-use because the ID instruction is wrong-path.
  3. hzd_load_use: hold_pc=1, hold_ifid=1, bubble_idex=1, hold_idex=0. Stay in RUN; exactly one bubble per asserted cycle.
  4. halt_req: hold_pc=1, flush_ifid=1; cnt<=1; go to DRAIN.
  5. Otherwise all outputs 0.
- MEM_WAIT:
  - ~mem_ack & cnt<MEM_WAIT_MAX: all holds=1; cnt<=cnt+1.
  - mem_ack: all holds=0 this cycle so the stage advances with the returned data; cnt<=0; go to RUN. halt_req and branch_taken are ignored in this cycle and must be held or re-presented by their sources.
  - ~mem_ack & cnt==MEM_WAIT_MAX: all holds=1; mem_timeout<=1; halted<=1; go to HALTED.
- DRAIN:
  - hold_pc=1 and flush_ifid=1 every cycle.
  - If stall: all holds=1 as well and cnt frozen.
  - Else: cnt<=cnt+1. When cnt==DRAIN_CYCLES, go to HALTED and set halted<=1.
  - branch_taken and hzd_load_use are ignored, because IF/ID only carries NOPs.
- HALTED:
  - hold_pc=hold_ifid=hold_idex=1; halted=1.
  - If resume & ~mem_timeout: go to RUN and halted<=0; outputs already follow RUN next cycle.
  - halt_req is ignored. resume is ignored while mem_timeout=1; only rst clears it.
- The counter never wraps; it saturates at 2^CNT_W-1 as a defensive measure.
- An undefined state recovers to RUN on the next edge.

Decomposition:
- Shared include/package stall_ctrl_defs:
  - state encodings ST_RUN=2'd0, ST_MEM_WAIT=2'd1, ST_DRAIN=2'd2, ST_HALTED=2'd3;
  - default constants for MEM_WAIT_MAX and DRAIN_CYCLES.
- One natural sub-module: wait_counter, a CNT_W-bit saturating up-counter with synchronous clear/load-1 and increment enable, built on the existing enable-flop primitives.
- The state register and output decode stay in stall_ctrl.

Test Plan:
1. Reset then idle: assert rst for 2 cycles with random inputs → all outputs 0 during and after reset; halted=0, mem_timeout=0.
2. Memory wait: mem_req=1, mem_ack=0 for 4 cycles, then mem_ack=1 → holds=1 for 4 cycles, all holds=0 in the ack cycle, state RUN after.
3. Timeout: mem_req=1, mem_ack never, MEM_WAIT_MAX=15 → holds for 16 cycles, then mem_timeout=1 and halted=1. resume=1 keeps halted=1. rst clears both.
4. Priority: branch_taken=1 and hzd_load_use=1 in the same RUN cycle → flush_ifid=1, bubble_idex=1, hold_pc=0. Load-use alone → hold_pc=1, hold_ifid=1, bubble_idex=1, hold_idex=0.
5. Halt: halt_req pulse, DRAIN_CYCLES=3, one stall cycle injected mid-drain → halted rises 4 cycles after the request (3 drain + 1 frozen). resume=1 → halted=0 next cycle, holds=0.
6. Reset mid-operation: rst=1 while in MEM_WAIT with cnt=7 → next cycle state RUN, cnt=0, outputs 0; a fresh stall restarts the count from 1.
